// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - RSA modular exponentiation C = M^E mod P via bit-serial Montgomery multiply (optional RSA_LZ_SKIP_EN)
module rsa_modexp_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Const,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int SW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_M,
        S_PRE_X,
        S_SQR,
        S_MUL,
        S_POST
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] mbar_q, mbar_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             a_bit;
    logic [SW-1:0]    p_ext;
    logic [SW-1:0]    s_add;
    logic [SW-1:0]    s_odd;
    logic [SW-1:0]    s_step;
    logic [WIDTH-1:0] mm_res;
    logic             mm_last;
    logic             e_bit;
    logic             i_zero;

    // Montgomery operand routing: each state multiplies a fixed pair of values
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        case (state_q)
            S_PRE_M: begin a_sel = m_q;          b_sel = k_q;          end
            S_PRE_X: begin a_sel = WIDTH'(1);    b_sel = k_q;          end
            S_SQR:   begin a_sel = x_q;          b_sel = x_q;          end
            S_MUL:   begin a_sel = x_q;          b_sel = mbar_q;       end
            S_POST:  begin a_sel = x_q;          b_sel = WIDTH'(1);    end
            default: begin a_sel = '0;           b_sel = '0;           end
        endcase
    end

    // One bit-serial Montgomery step plus the final conditional subtraction
    always_comb begin
        a_bit   = |(a_sel & (WIDTH'(1) << cnt_q));
        p_ext   = {2'b00, p_q};
        s_add   = s_q + (a_bit ? {2'b00, b_sel} : '0);
        s_odd   = s_add + (s_add[0] ? p_ext : '0);
        s_step  = s_odd >> 1;
        mm_res  = (s_q >= p_ext) ? WIDTH'(s_q - p_ext) : WIDTH'(s_q);
        mm_last = (cnt_q == CW'(WIDTH));
        e_bit   = |(e_q & (WIDTH'(1) << i_q));
        i_zero  = (i_q == '0);
    end

`ifdef RSA_LZ_SKIP_EN
    logic [IW-1:0] msb_idx;

    // Priority encoder: index of the highest set bit of the latched exponent
    always_comb begin
        msb_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (e_q[k]) begin
                msb_idx = IW'(k);
            end
        end
    end
`endif

    // Sequencer: operand latch, MM step counting and square-and-multiply walk over E
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        k_d     = k_q;
        mbar_d  = mbar_q;
        x_d     = x_q;
        c_d     = c_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    p_d     = P;
                    e_d     = E;
                    m_d     = M;
                    k_d     = Const;
                    i_d     = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = S_PRE_M;
                end
            end
            default: begin
                if (abort) begin
                    // abandon the run; C keeps the last completed result
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    s_d     = '0;
                end else if (!mm_last) begin
                    s_d   = s_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    s_d   = '0;
                    case (state_q)
                        S_PRE_M: begin
                            mbar_d  = mm_res;
                            state_d = S_PRE_X;
                        end
                        S_PRE_X: begin
                            x_d = mm_res;
`ifdef RSA_LZ_SKIP_EN
                            if (e_q == '0) begin
                                state_d = S_POST;
                            end else begin
                                i_d     = msb_idx;
                                state_d = S_SQR;
                            end
`else
                            state_d = S_SQR;
`endif
                        end
                        S_SQR: begin
                            x_d = mm_res;
                            if (e_bit) begin
                                state_d = S_MUL;
                            end else if (i_zero) begin
                                state_d = S_POST;
                            end else begin
                                i_d     = i_q - IW'(1);
                                state_d = S_SQR;
                            end
                        end
                        S_MUL: begin
                            x_d = mm_res;
                            if (i_zero) begin
                                state_d = S_POST;
                            end else begin
                                i_d     = i_q - IW'(1);
                                state_d = S_SQR;
                            end
                        end
                        S_POST: begin
                            c_d     = mm_res;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers: reset wins over ena, ena low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            mbar_q  <= '0;
            x_q     <= '0;
            c_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            k_q     <= k_d;
            mbar_q  <= mbar_d;
            x_q     <= x_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb/tb_rsa_modexp_engine.sv - randomized model-checked bench for rsa_modexp_engine at WIDTH 8 and 16
module tb_rsa_modexp_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        start8, abort8, busy8, done8;
    logic [7:0]  p8, e8, m8, k8, c8;
    logic        start16, abort16, busy16, done16;
    logic [15:0] p16, e16, m16, k16, c16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsa_modexp_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .start(start8), .abort(abort8),
        .P(p8), .E(e8), .M(m8), .Const(k8),
        .busy(busy8), .done(done8), .C(c8)
    );

    rsa_modexp_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .ena(ena), .start(start16), .abort(abort16),
        .P(p16), .E(e16), .M(m16), .Const(k16),
        .busy(busy16), .done(done16), .C(c16)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_modexp(input longint m, input longint e, input longint p, input int w);
        longint r;
        longint b;
        r = 1;
        b = m % p;
        for (int i = w - 1; i >= 0; i--) begin
            r = (r * r) % p;
            if ((e >> i) & 1) r = (r * b) % p;
        end
        return r % p;
    endfunction

    function automatic int ref_latency(input longint e, input int w);
        int pop;
        int msb;
        int n;
        pop = 0;
        msb = -1;
        for (int i = 0; i < w; i++) begin
            if ((e >> i) & 1) begin
                pop++;
                msb = i;
            end
        end
`ifdef RSA_LZ_SKIP_EN
        n = (e == 0) ? 3 : 3 + (msb + 1) + pop;
`else
        n = 3 + w + pop;
`endif
        return n * (w + 1);
    endfunction

    function automatic longint r2_mod(input longint p, input int w);
        longint r2;
        r2 = longint'(1) << (2 * w);
        return r2 % p;
    endfunction

    function automatic longint get_busy(input int w);
        return (w == 16) ? longint'(busy16) : longint'(busy8);
    endfunction

    function automatic longint get_done(input int w);
        return (w == 16) ? longint'(done16) : longint'(done8);
    endfunction

    function automatic longint get_c(input int w);
        return (w == 16) ? longint'(c16) : longint'(c8);
    endfunction

    task automatic drive(input int w, input longint p, input longint e, input longint m,
                         input longint k, input logic st, input logic ab);
        if (w == 16) begin
            p16 = 16'(p); e16 = 16'(e); m16 = 16'(m); k16 = 16'(k);
            start16 = st; abort16 = ab;
        end else begin
            p8 = 8'(p); e8 = 8'(e); m8 = 8'(m); k8 = 8'(k);
            start8 = st; abort8 = ab;
        end
    endtask

    // mode 0: plain run; 1: start pulse and M change while busy; 2: ena low for 10 cycles
    task automatic run_op(input int w, input longint p, input longint e, input longint m,
                          input longint k, input int mode, output int lat);
        drive(w, p, e, m, k, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(w, p, e, m, k, 1'b0, 1'b0);
        check_val("busy_after_start", get_busy(w), 1);
        lat = 0;
        while (get_done(w) == 0 && lat < 4000) begin
            if (mode == 1 && lat == 10) drive(w, p, e, m, k, 1'b1, 1'b0);
            if (mode == 1 && lat == 11) drive(w, p, e, (m + 1) % p, k, 1'b0, 1'b0);
            if (mode == 2 && lat == 30) ena = 1'b0;
            if (mode == 2 && lat == 40) ena = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1;
        if (lat >= 4000) check_val("done_timeout", lat, -1);
    endtask

    task automatic run_check(input string tag, input int w, input longint p, input longint e,
                             input longint m, input longint k, input int mode, input int extra,
                             input bit pulse_chk);
        int lat;
        run_op(w, p, e, m, k, mode, lat);
        check_val({tag, "_C"}, get_c(w), ref_modexp(m, e, p, w));
        check_val({tag, "_latency"}, lat, ref_latency(e, w) + extra);
        if (pulse_chk) begin
            @(posedge clk); #1;
            check_val({tag, "_done_pulse"}, get_done(w), 0);
            check_val({tag, "_busy_idle"}, get_busy(w), 0);
        end
    endtask

    initial begin
        int  lat;
        bit  seen_done;
        longint rp, re, rm;

        rst = 1'b1;
        ena = 1'b1;
        drive(8, 0, 0, 0, 0, 1'b0, 1'b0);
        drive(16, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy8", busy8, 0);
        check_val("reset_done8", done8, 0);
        check_val("reset_c8", c8, 0);
        check_val("reset_busy16", busy16, 0);
        check_val("reset_done16", done16, 0);
        check_val("reset_c16", c16, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_check("p187", 8, 187, 7, 2, 86, 0, 0, 1'b1);
        check_val("p187_expected_c", c8, 128);
        run_check("p33e3", 8, 33, 3, 4, 31, 0, 0, 1'b0);
        check_val("p33e3_expected_c", c8, 31);
        run_check("p33e0_back_to_back", 8, 33, 0, 5, 31, 0, 0, 1'b1);
        check_val("p33e0_expected_c", c8, 1);

        // abort sampled at the 40th edge after start
        drive(8, 187, 7, 2, 86, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(8, 187, 7, 2, 86, 1'b0, 1'b0);
        repeat (39) @(posedge clk);
        #1;
        drive(8, 187, 7, 2, 86, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 187, 7, 2, 86, 1'b0, 1'b0);
        check_val("abort_busy", busy8, 0);
        check_val("abort_done", done8, 0);
        check_val("abort_c_held", c8, 1);
        seen_done = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done8) seen_done = 1'b1;
        end
        check_val("abort_no_done", seen_done, 0);
        check_val("abort_c_still_held", c8, 1);

        run_check("after_abort", 8, 187, 7, 2, 86, 0, 0, 1'b1);
        run_check("disturb", 8, 187, 7, 2, 86, 1, 0, 1'b1);
        run_check("ena_stall", 8, 187, 7, 2, 86, 2, 10, 1'b1);

        run_check("w16_enc", 16, 3233, 17, 65, 1155, 0, 0, 1'b1);
        check_val("w16_enc_expected_c", c16, 2790);
        run_check("w16_dec", 16, 3233, 2753, 2790, 1155, 0, 0, 1'b1);
        check_val("w16_dec_expected_c", c16, 65);

        for (int n = 0; n < 8; n++) begin
            rp = longint'($urandom_range(1, 127)) * 2 + 1;
            rm = longint'($urandom_range(0, 32'(rp - 1)));
            re = (n == 0) ? 0 : longint'($urandom_range(0, 255));
            run_check("rand8", 8, rp, re, rm, r2_mod(rp, 8), 0, 0, 1'b1);
        end
        for (int n = 0; n < 4; n++) begin
            rp = longint'($urandom_range(1, 32767)) * 2 + 1;
            rm = longint'($urandom_range(0, 32'(rp - 1)));
            re = (n == 0) ? 65535 : longint'($urandom_range(0, 65535));
            run_check("rand16", 16, rp, re, rm, r2_mod(rp, 16), 0, 0, 1'b1);
        end

        // synchronous reset in the middle of a run
        drive(8, 33, 3, 4, 31, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(8, 33, 3, 4, 31, 1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrun_rst_busy", busy8, 0);
        check_val("midrun_rst_done", done8, 0);
        check_val("midrun_rst_c", c8, 0);

        // start and abort together in IDLE: abort wins
        drive(8, 187, 7, 2, 86, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(8, 187, 7, 2, 86, 1'b0, 1'b0);
        check_val("start_abort_idle_busy", busy8, 0);
        seen_done = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen_done = 1'b1;
        end
        check_val("start_abort_stays_idle", seen_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
Parametrised successor to the 8-bit RSA unit. Computes C = M^E mod P with left-to-right square-and-multiply over a bit-serial Montgomery multiplier, with R = 2^WIDTH.
Adds a start/busy/done handshake, an abort input, operand latching and deterministic, documented latency.
Sits between the SPI register bank, which supplies P/E/M/Const, and the enable controller, which drives start/abort and consumes done as the IRQ source.

Parameters:
WIDTH, 8, operand width in bits for P, E, M, Const and C; legal range 4..32.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
ena  in  1  clock enable; when low, all state, counters and outputs freeze.
start  in  1  single-cycle request; sampled only in IDLE.
abort  in  1  cancels an operation in progress.
P  in  WIDTH  modulus; odd, P >= 3.
E  in  WIDTH  exponent.
M  in  WIDTH  message; M < P.
Const  in  WIDTH  R^2 mod P, with R = 2^WIDTH.
busy  out  1  high in every non-IDLE state.
done  out  1  single-cycle pulse when C is updated.
C  out  WIDTH  result; held until the next done or reset.

Behaviour:
- Reset (rst=1 at a clk edge, with ena ignored): state IDLE, busy=0, done=0, C=0, all internal registers cleared.
- States: IDLE, PRE_M, PRE_X, SQR, MUL, POST.
- IDLE, start=1, abort=0, ena=1: latch P, E, M and Const; set bit index i = WIDTH-1; go to PRE_M.
  - Operand changes after the latch are ignored.
- MM(A,B) primitive: occupies exactly WIDTH+1 enabled cycles, using counter 0..WIDTH and internal accumulator S of WIDTH+2 bits.
  - Cycles 0..WIDTH-1: S = S + A[j]*B; if S is odd, S = S + P; S = S >> 1. Bit j runs LSB first.
  - Cycle WIDTH: if S >= P, S = S - P. The result is < P.
- PRE_M: Mbar = MM(M, Const). Next state PRE_X.
- PRE_X: X = MM(1, Const). Next state SQR.
- SQR: X = MM(X, X). Next state is MUL if E[i]=1. Otherwise decrement i, or go to POST when i = 0.
- MUL: X = MM(X, Mbar). Decrement i and go to SQR, or go to POST when i = 0.
- POST: result = MM(X, 1). On completion: C = result, done = 1 for one cycle, state IDLE, busy = 0.
- Latency: start is sampled at edge k; done is high in the cycle after edge k + N*(WIDTH+1).
  - N = 3 + WIDTH + popcount(E).
- start while busy: ignored, no effect.
- start in the same cycle done is high: accepted, because the state is already IDLE.
- abort=1 with busy=1 and ena=1: go to IDLE at the next edge. done is not asserted and C is unchanged.
- abort=1 in IDLE: no effect. start and abort together in IDLE: abort wins and start is ignored.
- ena=0 mid-operation: operation stretches by the number of disabled cycles; the result is unaffected.
- Synchronous rst mid-operation: immediate return to reset values. No done pulse.
- P even, P < 3 or M >= P: result undefined, but the FSM must still terminate with the same latency and must not hang.
- E = 0: result is 1 (when P >= 3). Without the optional feature, latency is (3+WIDTH)*(WIDTH+1).

Optional Feature:
RSA_LZ_SKIP_EN
- Defined: after PRE_X, i starts at the index of the most-significant set bit of E, so leading zero exponent bits cost no cycles.
  - N = 3 + (msb_index+1) + popcount(E).
  - E = 0 goes straight from PRE_X to POST, giving N = 3.
  - Add a combinational priority encoder on the latched E.
- Undefined: iteration always starts at i = WIDTH-1. The latency formula is as above. No encoder logic is present.

Test Plan:
- WIDTH=8, P=187, E=7, M=2, Const=86, start pulse -> C=128.
  - done in cycle k+127 (without RSA_LZ_SKIP_EN) or k+82 (with it); busy high in between.
- WIDTH=8, P=33, E=3, M=4, Const=31 -> C=31.
  - Immediately start P=33, E=0, M=5 -> C=1; latency 99 cycles (without) or 27 (with).
- WIDTH=16, P=3233, E=17, M=65, Const=1155 -> C=2790.
  - Then with the same P and Const, E=2753, M=2790 -> C=65.
- Abort at cycle k+40 of the P=187 run -> busy low at k+41; no done; C keeps its previous value.
  - A following start runs normally.
- Toggle start during busy and change M mid-run -> ignored; C=128 with unchanged latency.
  - Hold ena=0 for 10 cycles mid-run -> done delayed by exactly 10 cycles.
- Assert rst mid-run -> next cycle busy=0, done=0, C=0.
  - Start and abort asserted together in IDLE -> stays IDLE.
